// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types for the hazard controller (forward selects, shadow slot record, match helper)
package rv32i_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              load;
  } hz_slot_t;
  // x0 is hardwired to zero, so a write to it never produces a dependency
  function automatic logic writes(hz_slot_t s, logic [REG_AW-1:0] r);
    return s.valid & s.regwrite & (s.rd == r) & (r != '0);
  endfunction
endpackage

// File: rtl/hazard_shadow_pipe.sv
// hazard_shadow_pipe: E/M/W shadow slots mirroring the instructions in flight
// Ports: clk, rst (async, active-high); stall_d/flush_e gate the E slot;
// d_slot is the decode-stage record; e_slot/m_slot/w_slot are the shadow stages.
module hazard_shadow_pipe
  import rv32i_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     stall_d,
  input  logic     flush_e,
  input  hz_slot_t d_slot,
  output hz_slot_t e_slot,
  output hz_slot_t m_slot,
  output hz_slot_t w_slot
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_slot <= '0;
      m_slot <= '0;
      w_slot <= '0;
    end else begin
      w_slot <= m_slot;
      m_slot <= e_slot;
      if (flush_e) e_slot <= '0;
      else if (!stall_d) e_slot <= d_slot;
    end
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush/forward control for the five-stage RV32I pipeline
// Ports: clk, rst (async, active-high); decode inputs validD, rs1D, rs2D, RdD,
// regwriteD, resultsrcD; pcsrcE (taken branch in E); outputs stallF, stallD,
// flushD, flushE, forwardAE/forwardBE (fwd_sel_t), forwardAD/forwardBD.
// Macro HAZARD_FWD_EN: enables E-stage forwarding (only load-use stalls);
// without it every RAW on E or M interlocks until the producer reaches W.
module hazard_ctrl_unit
  import rv32i_pkg::*;
#(
  parameter int ADW = REG_AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           validD,
  input  logic [ADW-1:0] rs1D,
  input  logic [ADW-1:0] rs2D,
  input  logic [ADW-1:0] RdD,
  input  logic           regwriteD,
  input  logic           resultsrcD,
  input  logic           pcsrcE,
  output logic           stallF,
  output logic           stallD,
  output logic           flushD,
  output logic           flushE,
  output fwd_sel_t       forwardAE,
  output fwd_sel_t       forwardBE,
  output logic           forwardAD,
  output logic           forwardBD
);
  hz_slot_t d_slot, e_slot, m_slot, w_slot;
  logic     hz;
  logic     unused_fields;
  assign d_slot = '{validD, rs1D, rs2D, RdD, regwriteD, resultsrcD};
  hazard_shadow_pipe u_pipe (
    .clk     (clk),
    .rst     (rst),
    .stall_d (stallD),
    .flush_e (flushE),
    .d_slot  (d_slot),
    .e_slot  (e_slot),
    .m_slot  (m_slot),
    .w_slot  (w_slot)
  );
  // register file writes and reads on the same edge, so W must bypass into D
  assign forwardAD = validD & writes(w_slot, rs1D);
  assign forwardBD = validD & writes(w_slot, rs2D);
`ifdef HAZARD_FWD_EN
  assign hz = validD & e_slot.load & (writes(e_slot, rs1D) | writes(e_slot, rs2D));
  assign forwardAE = writes(m_slot, e_slot.rs1) ? FWD_MEM : writes(w_slot, e_slot.rs1) ? FWD_WB : FWD_NONE;
  assign forwardBE = writes(m_slot, e_slot.rs2) ? FWD_MEM : writes(w_slot, e_slot.rs2) ? FWD_WB : FWD_NONE;
  assign unused_fields = ^{m_slot.rs1, m_slot.rs2, m_slot.load, w_slot.rs1, w_slot.rs2, w_slot.load};
`else
  assign hz = validD & (writes(e_slot, rs1D) | writes(e_slot, rs2D) | writes(m_slot, rs1D) | writes(m_slot, rs2D));
  assign forwardAE = FWD_NONE;
  assign forwardBE = FWD_NONE;
  assign unused_fields = ^{e_slot.rs1, e_slot.rs2, e_slot.load, m_slot.rs1, m_slot.rs2, m_slot.load,
                           w_slot.rs1, w_slot.rs2, w_slot.load};
`endif
  // a taken branch squashes the stalled instruction anyway, so it releases the stall
  assign stallF = hz & ~pcsrcE;
  assign stallD = hz & ~pcsrcE;
  assign flushD = pcsrcE;
  assign flushE = hz | pcsrcE;
endmodule
